// File: rtl/trace_logger_if.sv
`default_nettype none
// ============================================================================
// Module   : trace_logger_if
// Purpose  : Tracer / trace-memory signal bundle for trace_logger.
//            Optional FILL_O present when TRB_LOGGER_FILL_LEVEL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface trace_logger_if #(
  parameter int TRB_WIDTH       = 32,
  parameter int TRB_DEPTH       = 64,
  parameter int TRB_ADDR_WIDTH  = $clog2(TRB_DEPTH),
  parameter int TRB_DELAY_BITS  = 4,
  parameter int TRB_NTRACE_BITS = 3
);
  localparam int POS_W  = $clog2(TRB_WIDTH);
  localparam int STAT_W = 1 + TRB_ADDR_WIDTH + POS_W;

  logic                       CONF_TRG_MODE_I;
  logic [TRB_NTRACE_BITS-1:0] CONF_TRG_NUM_TRACES_I;
  logic [TRB_DELAY_BITS-1:0]  CONF_TRG_DELAY_I;
  logic [STAT_W-1:0]          STAT_O;
  logic                       RW_TURN_I;
  logic                       WRITE_O;
  logic                       WRITE_ALLOW_I;
  logic                       READ_ALLOW_I;
  logic [TRB_ADDR_WIDTH-1:0]  READ_PTR_O;
  logic [TRB_WIDTH-1:0]       DMEM_I;
  logic [TRB_ADDR_WIDTH-1:0]  WRITE_PTR_O;
  logic [TRB_WIDTH-1:0]       DMEM_O;
  logic                       MODE_O;
  logic [TRB_NTRACE_BITS-1:0] NTRACE_O;
  logic [POS_W-1:0]           EVENT_POS_I;
  logic                       TRG_EVENT_I;
  logic                       TRG_DELAYED_O;
  logic [TRB_WIDTH-1:0]       DATA_O;
  logic                       LOAD_REQUEST_I;
  logic                       LOAD_GRANT_O;
  logic [TRB_WIDTH-1:0]       DATA_I;
  logic                       STORE_I;
  logic                       STORE_PERM_O;
`ifdef TRB_LOGGER_FILL_LEVEL_EN
  logic [TRB_ADDR_WIDTH-1:0]  FILL_O;
`endif

  modport slave (
    input  CONF_TRG_MODE_I, CONF_TRG_NUM_TRACES_I, CONF_TRG_DELAY_I,
    input  RW_TURN_I, WRITE_ALLOW_I, READ_ALLOW_I, DMEM_I,
    input  EVENT_POS_I, TRG_EVENT_I, LOAD_REQUEST_I, DATA_I, STORE_I,
`ifdef TRB_LOGGER_FILL_LEVEL_EN
    output FILL_O,
`endif
    output STAT_O, WRITE_O, READ_PTR_O, WRITE_PTR_O, DMEM_O, MODE_O, NTRACE_O,
    output TRG_DELAYED_O, DATA_O, LOAD_GRANT_O, STORE_PERM_O
  );

  modport master (
    output CONF_TRG_MODE_I, CONF_TRG_NUM_TRACES_I, CONF_TRG_DELAY_I,
    output RW_TURN_I, WRITE_ALLOW_I, READ_ALLOW_I, DMEM_I,
    output EVENT_POS_I, TRG_EVENT_I, LOAD_REQUEST_I, DATA_I, STORE_I,
`ifdef TRB_LOGGER_FILL_LEVEL_EN
    input  FILL_O,
`endif
    input  STAT_O, WRITE_O, READ_PTR_O, WRITE_PTR_O, DMEM_O, MODE_O, NTRACE_O,
    input  TRG_DELAYED_O, DATA_O, LOAD_GRANT_O, STORE_PERM_O
  );
endinterface
`default_nettype wire

// File: rtl/trace_logger.sv
`default_nettype none
// ============================================================================
// Module   : trace_logger
// Purpose  : Ring-buffer controller between the Tracer and the dual-slot TRB
//            memory; FILL_O added when TRB_LOGGER_FILL_LEVEL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module trace_logger #(
  parameter int TRB_WIDTH       = 32,
  parameter int TRB_DEPTH       = 64,
  parameter int TRB_ADDR_WIDTH  = $clog2(TRB_DEPTH),
  parameter int TRB_DELAY_BITS  = 4,
  parameter int TRB_NTRACE_BITS = 3
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  trace_logger_if.slave  bus
);
  localparam int POS_W = $clog2(TRB_WIDTH);
  localparam logic [TRB_ADDR_WIDTH-1:0] c_ptr_one  = TRB_ADDR_WIDTH'(1);
  localparam logic [TRB_ADDR_WIDTH-1:0] c_ptr_last = TRB_ADDR_WIDTH'(TRB_DEPTH - 1);

  logic [TRB_ADDR_WIDTH-1:0]  r_write_ptr;
  logic [TRB_ADDR_WIDTH-1:0]  r_read_ptr;
  logic                       r_hold_valid;
  logic [TRB_WIDTH-1:0]       r_hold_data;
  logic                       r_pending;
  logic                       r_rd_p1;
  logic                       r_rd_p2;
  logic                       r_rd_p3;
  logic                       r_grant;
  logic [TRB_WIDTH-1:0]       r_data;
  logic                       r_trg_event;
  logic [TRB_ADDR_WIDTH-1:0]  r_event_addr;
  logic [POS_W-1:0]           r_event_pos;
  logic [TRB_DELAY_BITS-1:0]  r_delay_cnt;
  logic                       r_trg_delayed;
  logic                       r_mode;
  logic [TRB_NTRACE_BITS-1:0] r_ntrace;

  logic w_empty;
  logic w_full;
  logic w_store_perm;
  logic w_store;
  logic w_write;
  logic w_issue;
  logic w_trigger;

  // read_ptr points at the last consumed slot, so one slot always stays unused
  assign w_empty      = ((r_read_ptr + c_ptr_one) == r_write_ptr);
  assign w_full       = (r_write_ptr == r_read_ptr);
  assign w_store_perm = !r_hold_valid && !(r_mode && r_trg_delayed) && !(!r_mode && w_full);
  assign w_store      = bus.STORE_I && w_store_perm;
  assign w_write      = r_hold_valid && !bus.RW_TURN_I && bus.WRITE_ALLOW_I && (!w_full || r_mode);
  assign w_issue      = r_pending && !w_empty && bus.RW_TURN_I && bus.READ_ALLOW_I &&
                        (!r_mode || r_trg_delayed);
  assign w_trigger    = bus.TRG_EVENT_I && !r_trg_event;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_write_ptr   <= '0;
      r_read_ptr    <= c_ptr_last;
      r_hold_valid  <= 1'b0;
      r_hold_data   <= '0;
      r_pending     <= 1'b0;
      r_rd_p1       <= 1'b0;
      r_rd_p2       <= 1'b0;
      r_rd_p3       <= 1'b0;
      r_grant       <= 1'b0;
      r_data        <= '0;
      r_trg_event   <= 1'b0;
      r_event_addr  <= '0;
      r_event_pos   <= '0;
      r_delay_cnt   <= '0;
      r_trg_delayed <= 1'b0;
      r_mode        <= 1'b0;
      r_ntrace      <= '0;
    end else begin
      r_mode   <= bus.CONF_TRG_MODE_I;
      r_ntrace <= bus.CONF_TRG_NUM_TRACES_I;

      if (w_store) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= bus.DATA_I;
      end else if (w_write) begin
        r_hold_valid <= 1'b0;
      end

      if (w_write)
        r_write_ptr <= r_write_ptr + c_ptr_one;
      // capture-mode overwrite of a full ring drops the oldest word
      if (w_issue || (w_write && w_full))
        r_read_ptr <= r_read_ptr + c_ptr_one;

      if (w_issue)
        r_pending <= 1'b0;
      else if (bus.LOAD_REQUEST_I)
        r_pending <= 1'b1;

      // issue -> RAM address sample -> data capture -> grant
      r_rd_p1 <= w_issue;
      r_rd_p2 <= r_rd_p1;
      r_rd_p3 <= r_rd_p2;
      r_grant <= r_rd_p3;
      if (r_rd_p2)
        r_data <= bus.DMEM_I;

      if (w_trigger) begin
        r_trg_event  <= 1'b1;
        r_event_addr <= r_write_ptr;
        r_event_pos  <= bus.EVENT_POS_I;
        r_delay_cnt  <= bus.CONF_TRG_DELAY_I;
      end else if (r_trg_event && w_write && (r_delay_cnt != '0)) begin
        r_delay_cnt <= r_delay_cnt - TRB_DELAY_BITS'(1);
      end

      r_trg_delayed <= r_trg_delayed || (r_trg_event && (r_delay_cnt == '0));
    end
  end

  assign bus.STAT_O        = {r_trg_event, r_event_addr, r_event_pos};
  assign bus.WRITE_O       = w_write;
  assign bus.READ_PTR_O    = r_read_ptr;
  assign bus.WRITE_PTR_O   = r_write_ptr;
  assign bus.DMEM_O        = r_hold_data;
  assign bus.MODE_O        = r_mode;
  assign bus.NTRACE_O      = r_ntrace;
  assign bus.TRG_DELAYED_O = r_trg_delayed;
  assign bus.DATA_O        = r_data;
  assign bus.LOAD_GRANT_O  = r_grant;
  assign bus.STORE_PERM_O  = w_store_perm;

`ifdef TRB_LOGGER_FILL_LEVEL_EN
  assign bus.FILL_O = RST_I ? '0 : (r_write_ptr - r_read_ptr - c_ptr_one);
`endif

endmodule
`default_nettype wire

// File: tb/tb_trace_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_logger
// Purpose  : Directed self-checking bench for trace_logger with a sync-read
//            RAM model; checks FILL_O when TRB_LOGGER_FILL_LEVEL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_logger;
  localparam int W = 32;
  localparam int D = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trace_logger_if bus ();
  trace_logger dut (.CLK_I(clk), .RST_I(rst), .bus(bus));

  logic [W-1:0] mem [D];
  logic [W-1:0] mem_q;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else if (bus.WRITE_O) begin
      mem[bus.WRITE_PTR_O] <= bus.DMEM_O;
    end
    mem_q <= mem[bus.READ_PTR_O];
  end
  assign bus.DMEM_I = mem_q;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.STORE_I = 0; bus.LOAD_REQUEST_I = 0; bus.TRG_EVENT_I = 0;
    bus.RW_TURN_I = 1; bus.WRITE_ALLOW_I = 0; bus.READ_ALLOW_I = 0;
    bus.DATA_I = '0; bus.EVENT_POS_I = '0;
    bus.CONF_TRG_MODE_I = 0; bus.CONF_TRG_NUM_TRACES_I = '0; bus.CONF_TRG_DELAY_I = '0;
  endtask

  task automatic do_reset();
    rst = 1; idle(); tick(); tick(); rst = 0;
  endtask

  // one store cycle (read slot, so nothing writes) then one write slot
  task automatic store_and_write(input logic [W-1:0] data, output bit wrote);
    bus.DATA_I = data; bus.STORE_I = 1; bus.RW_TURN_I = 1; bus.READ_ALLOW_I = 0;
    tick();
    bus.STORE_I = 0; bus.RW_TURN_I = 0; bus.WRITE_ALLOW_I = 1;
    #1; wrote = bus.WRITE_O;
    tick();
    bus.WRITE_ALLOW_I = 0; bus.RW_TURN_I = 1;
  endtask

  task automatic wait_grant(input string tag, input logic [W-1:0] exp);
    bit seen = 0;
    bus.RW_TURN_I = 1; bus.READ_ALLOW_I = 1;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (bus.LOAD_GRANT_O) seen = 1;
    end
    bus.READ_ALLOW_I = 0;
    check({tag, "_grant"}, seen, 1);
    check({tag, "_data"}, bus.DATA_O, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wr;
    bit seen;
    int cnt;
    int w;
    int rise_w;

    // reset state
    do_reset();
    check("rst_wptr", bus.WRITE_PTR_O, 0);
    check("rst_rptr", bus.READ_PTR_O, 63);
    check("rst_stat", bus.STAT_O, 0);
    check("rst_perm", bus.STORE_PERM_O, 1);
    check("rst_delayed", bus.TRG_DELAYED_O, 0);
    check("rst_grant", bus.LOAD_GRANT_O, 0);
    check("rst_data", bus.DATA_O, 0);
    check("rst_dmem", bus.DMEM_O, 0);
    check("rst_write", bus.WRITE_O, 0);

    // load on empty buffer, then one word with exact grant latency
    bus.CONF_TRG_NUM_TRACES_I = 3'd5;
    bus.LOAD_REQUEST_I = 1; bus.RW_TURN_I = 1; bus.READ_ALLOW_I = 1;
    #1; check("ntrace_pre", bus.NTRACE_O, 0);
    tick();
    bus.LOAD_REQUEST_I = 0;
    check("ntrace_reg", bus.NTRACE_O, 5);
    seen = 0;
    repeat (5) begin tick(); if (bus.LOAD_GRANT_O) seen = 1; end
    check("empty_rptr", bus.READ_PTR_O, 63);
    check("empty_nogrant", seen, 0);
    bus.READ_ALLOW_I = 0;
    store_and_write(32'hA5A5_A5A5, wr);
    check("a5_wrote", wr, 1);
    bus.READ_ALLOW_I = 1;
    tick();
    bus.READ_ALLOW_I = 0;
    check("a5_issue_rptr", bus.READ_PTR_O, 0);
    tick(); check("a5_grant_e1", bus.LOAD_GRANT_O, 0);
    tick(); check("a5_grant_e2", bus.LOAD_GRANT_O, 0);
    tick(); check("a5_grant_e3", bus.LOAD_GRANT_O, 1);
    check("a5_data", bus.DATA_O, 32'hA5A5_A5A5);
    tick(); check("a5_grant_pulse", bus.LOAD_GRANT_O, 0);
    check("a5_data_hold", bus.DATA_O, 32'hA5A5_A5A5);

    // stream mode fill to full
    do_reset();
    cnt = 0;
    for (int i = 0; i < 63; i++) begin
      store_and_write(32'h1000 + i, wr);
      cnt += int'(wr);
    end
    check("fill_writes", cnt, 63);
    check("fill_wptr", bus.WRITE_PTR_O, 63);
    check("fill_rptr", bus.READ_PTR_O, 63);
    check("fill_perm", bus.STORE_PERM_O, 0);
`ifdef TRB_LOGGER_FILL_LEVEL_EN
    check("fill_level", bus.FILL_O, 63);
`endif
    store_and_write(32'hDEAD, wr);
    check("full_nowrite", wr, 0);
    check("full_wptr", bus.WRITE_PTR_O, 63);

    // capture mode: trigger bookkeeping, delay 2, reads only after delay
    do_reset();
    bus.CONF_TRG_MODE_I = 1;
    tick();
    check("cap_mode", bus.MODE_O, 1);
    for (int i = 0; i < 5; i++) store_and_write(32'hC000_0000 + i, wr);
    bus.LOAD_REQUEST_I = 1; bus.READ_ALLOW_I = 1;
    tick();
    bus.LOAD_REQUEST_I = 0;
    seen = 0;
    repeat (6) begin tick(); if (bus.LOAD_GRANT_O) seen = 1; end
    bus.READ_ALLOW_I = 0;
    check("cap_pre_nogrant", seen, 0);
    check("cap_pre_rptr", bus.READ_PTR_O, 63);
    bus.CONF_TRG_DELAY_I = 4'd2; bus.EVENT_POS_I = 5'd17; bus.TRG_EVENT_I = 1;
    tick();
    bus.TRG_EVENT_I = 0;
    check("trg_stat", bus.STAT_O, {1'b1, 6'd5, 5'd17});
    check("trg_not_delayed", bus.TRG_DELAYED_O, 0);
    bus.EVENT_POS_I = 5'd3; bus.TRG_EVENT_I = 1;
    tick();
    bus.TRG_EVENT_I = 0;
    check("trg2_stat", bus.STAT_O, {1'b1, 6'd5, 5'd17});
    store_and_write(32'hC000_0005, wr);
    store_and_write(32'hC000_0006, wr);
    check("dly2_not_yet", bus.TRG_DELAYED_O, 0);
    tick();
    check("dly2_delayed", bus.TRG_DELAYED_O, 1);
    check("dly2_perm", bus.STORE_PERM_O, 0);
    wait_grant("cap_read", 32'hC000_0000);

    // delay sweep with random slot/allow pattern
    for (int d = 15; d >= 0; d--) begin
      do_reset();
      bus.CONF_TRG_DELAY_I = d[3:0];
      bus.TRG_EVENT_I = 1;
      tick();
      bus.TRG_EVENT_I = 0;
      bus.STORE_I = 1;
      w = 0; rise_w = -1;
      for (int c = 0; c < 300 && rise_w < 0; c++) begin
        bus.DATA_I = $urandom;
        bus.RW_TURN_I = 1'($urandom_range(0, 1));
        bus.WRITE_ALLOW_I = 1'($urandom_range(0, 1));
        bus.READ_ALLOW_I = 1'($urandom_range(0, 1));
        #1; wr = bus.WRITE_O;
        tick();
        if (bus.TRG_DELAYED_O) rise_w = w;
        w += int'(wr);
      end
      bus.STORE_I = 0;
      check($sformatf("sweep_d%0d", d), rise_w, d);
    end

    // capture mode overwrite: 70 writes, oldest retained is word 7
    do_reset();
    bus.CONF_TRG_MODE_I = 1;
    tick();
    cnt = 0;
    for (int i = 0; i < 70; i++) begin
      store_and_write(32'h100 + i, wr);
      cnt += int'(wr);
    end
    check("ovr_writes", cnt, 70);
    check("ovr_wptr", bus.WRITE_PTR_O, 6);
    check("ovr_rptr", bus.READ_PTR_O, 6);
    check("ovr_perm", bus.STORE_PERM_O, 1);
    bus.CONF_TRG_DELAY_I = 4'd0; bus.TRG_EVENT_I = 1;
    tick();
    bus.TRG_EVENT_I = 0;
    check("ovr_stat", bus.STAT_O, {1'b1, 6'd6, 5'd0});
    tick();
    check("ovr_delayed", bus.TRG_DELAYED_O, 1);
    bus.LOAD_REQUEST_I = 1;
    tick();
    bus.LOAD_REQUEST_I = 0;
    wait_grant("ovr_read", 32'h107);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
